// File: rtl/nr_pkg.sv
// Shared types and widths for the Newton-Raphson based divider.
package nr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RECIP_REQ,
    S_RECIP_WAIT,
    S_MUL,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int unsigned OP_W       = 16;
  localparam int unsigned RECIP_W    = 24;
  localparam int unsigned RECIP_FRAC = 19;
  localparam int unsigned Q_FRAC     = 8;
  localparam int unsigned Q_W        = 24;
  localparam int unsigned PROD_W     = OP_W + RECIP_W;
  localparam int unsigned MUL_ITERS  = OP_W;
  // Product bit holding quotient weight 2^-8, and first bit above the [15:-8] window
  localparam int unsigned Q_LSB      = RECIP_FRAC - Q_FRAC;
  localparam int unsigned Q_TOP      = Q_LSB + Q_W;

  localparam logic [Q_W-1:0] Q_SAT = 24'hFFFFFF;

  // Slice P[15:-8] out of the product, saturating when P[20:16] is non-zero
  function automatic logic [Q_W-1:0] quotient_of(input logic [PROD_W-1:0] p);
    if ((p >> Q_TOP) != '0) begin
      return Q_SAT;
    end
    return Q_W'(p >> Q_LSB);
  endfunction

endpackage

// File: rtl/mul_shift_add_16x24.sv
// 16x24 shift-add multiplier: one multiplier bit per cycle, LSB first.
// A sentinel bit above the multiplier marks the end of the 16 iterations.
module mul_shift_add_16x24
  import nr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      multiplier,
  input  logic [RECIP_W-1:0]   multiplicand,
  output logic                 ready,
  output logic [PROD_W-1:0]    product
);

  logic [OP_W:0]       mplier;
  logic [PROD_W-1:0]   mcand;
  logic                running_c;
  logic                last_c;

  assign running_c = (mplier[OP_W:1] != '0);
  assign last_c    = (mplier[OP_W:1] == OP_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mplier  <= '0;
      mcand   <= '0;
      product <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        mplier  <= {1'b1, multiplier};
        mcand   <= PROD_W'(multiplicand);
        product <= '0;
      end else if (running_c) begin
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mplier <= mplier >> 1;
        mcand  <= mcand << 1;
        ready  <= last_c;
      end
    end
  end

endmodule

// File: rtl/nr_divider.sv
// Unsigned 16/16 divider using an external reciprocal unit and a shift-add multiply.
// Define NR_DIV_ROUND_EN to round the quotient half-up at 2^-9 instead of truncating.
module nr_divider
  import nr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      dividend,
  input  logic [OP_W-1:0]      divisor,
  output logic                 ready,
  output logic                 busy,
  output logic [Q_W-1:0]       quotient,
  output logic                 div_by_zero,
  output logic                 timeout_err,
  output logic                 recip_start,
  output logic [OP_W-1:0]      recip_input0,
  input  logic                 recip_ready,
  input  logic [RECIP_W-1:0]   recip_output0
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 4) ? CNT_RAW : 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
`ifdef NR_DIV_ROUND_EN
  localparam logic [PROD_W-1:0] ROUND_INC = PROD_W'(1) << (Q_LSB - 1);
`else
  localparam logic [PROD_W-1:0] ROUND_INC = '0;
`endif

  state_t              state, state_d;
  logic [OP_W-1:0]     dividend_q, divisor_q;
  logic [CNT_W-1:0]    cnt;
  logic                ready_d, busy_d, dbz_d, tmo_d, recip_start_d;
  logic [Q_W-1:0]      quotient_d;
  logic [OP_W-1:0]     recip_input_d;
  logic                mul_start_c;
  logic                mul_ready;
  logic [PROD_W-1:0]   product;
  logic [PROD_W-1:0]   rounded_c;

  mul_shift_add_16x24 u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start_c),
    .multiplier   (dividend_q),
    .multiplicand (recip_output0),
    .ready        (mul_ready),
    .product      (product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (start) state_d = S_CHECK;
      S_CHECK:      state_d = (divisor_q == '0) ? S_DONE : S_RECIP_REQ;
      S_RECIP_REQ:  state_d = S_RECIP_WAIT;
      S_RECIP_WAIT: begin
        if (recip_ready) begin
          state_d = S_MUL;
        end else if (cnt == CNT_MAX) begin
          state_d = S_DONE;
        end
      end
      S_MUL:        if (cnt == MUL_LAST) state_d = S_ROUND;
      S_ROUND:      state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the reciprocal answer wins over a same-cycle timeout
  always_comb begin
    ready_d       = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
    recip_start_d = (state_d == S_RECIP_REQ);
    recip_input_d = recip_input0;
    quotient_d    = quotient;
    dbz_d         = div_by_zero;
    tmo_d         = timeout_err;
    mul_start_c   = 1'b0;
    rounded_c     = product + ROUND_INC;
    case (state)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          tmo_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (divisor_q == '0) begin
          dbz_d      = 1'b1;
          quotient_d = Q_SAT;
        end else begin
          recip_input_d = divisor_q;
        end
      end
      S_RECIP_WAIT: begin
        if (recip_ready) begin
          mul_start_c = 1'b1;
        end else if (cnt == CNT_MAX) begin
          tmo_d      = 1'b1;
          quotient_d = Q_SAT;
        end
      end
      S_ROUND: begin
        if (mul_ready) begin
          quotient_d = quotient_of(rounded_c);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready        <= 1'b0;
      busy         <= 1'b0;
      quotient     <= '0;
      div_by_zero  <= 1'b0;
      timeout_err  <= 1'b0;
      recip_start  <= 1'b0;
      recip_input0 <= '0;
    end else begin
      ready        <= ready_d;
      busy         <= busy_d;
      quotient     <= quotient_d;
      div_by_zero  <= dbz_d;
      timeout_err  <= tmo_d;
      recip_start  <= recip_start_d;
      recip_input0 <= recip_input_d;
    end
  end

  // Operand capture; cnt is the reciprocal wait counter, then the multiply iteration index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
          end
        end
        S_RECIP_REQ: cnt <= '0;
        S_RECIP_WAIT: begin
          if (recip_ready) begin
            cnt <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_MUL: cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
